// File: rtl/chal_responder.sv
// Responder end of the UART challenge-response link: parses "CHAL:<32 hex>\n",
// runs the external ChaCha20 core on the nonce and transmits "RESP:<32 hex>\n".
module chal_responder #(
    parameter logic [23:0] BYTE_TIMEOUT = 24'd1_200_000,
    parameter logic [15:0] CORE_TIMEOUT = 16'd20_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_busy,
    output logic         core_start,
    input  logic         core_ready,
    output logic [127:0] core_nonce,
    input  logic [127:0] core_result,
    input  logic         core_valid,
    output logic         busy,
    output logic         parse_err,
    output logic         resp_done
);
    localparam int unsigned NONCE_W = 128;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned BTMR_W  = 24;
    localparam int unsigned CTMR_W  = 16;

    localparam logic [IDX_W-1:0] LAST_NIB   = IDX_W'(31);
    localparam logic [IDX_W-1:0] FIRST_HEX  = IDX_W'(5);
    localparam logic [IDX_W-1:0] LAST_BYTE  = IDX_W'(37);

    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_HEX   = 3'd2;
    localparam logic [2:0] S_EOL   = 3'd3;
    localparam logic [2:0] S_START = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_SEND  = 3'd6;

    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [2:0]         state_q, state_d;
    logic [2:0]         hdr_idx_q, hdr_idx_d;
    logic [IDX_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic               cr_seen_q, cr_seen_d;
    logic [BTMR_W-1:0]  byte_tmr_q, byte_tmr_d;
    logic [CTMR_W-1:0]  core_tmr_q, core_tmr_d;
    logic [NONCE_W-1:0] nonce_d;
    logic [NONCE_W-1:0] res_q, res_d;
    logic [IDX_W-1:0]   send_idx_q, send_idx_d;
    logic               outst_q, outst_d;
    logic               seen_busy_q, seen_busy_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic [7:0]         tx_data_d;
    logic               tx_valid_d, core_start_d, busy_d, parse_err_d, resp_done_d;

    logic [4:0]         rx_hex;
    logic [7:0]         hdr_exp;
    logic [7:0]         send_char;
    logic               byte_expired;
    logic               advance;

    // Returns {valid, nibble} for an ASCII hex digit of either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        else                               return 5'd0;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign rx_hex       = hex_decode(rx_data);
    assign byte_expired = (BYTE_TIMEOUT != 24'd0) && (byte_tmr_q == BYTE_TIMEOUT);

    always_comb begin
        case (hdr_idx_q)
            3'd1:    hdr_exp = 8'h48;
            3'd2:    hdr_exp = 8'h41;
            3'd3:    hdr_exp = 8'h4C;
            default: hdr_exp = 8'h3A;
        endcase
    end

    // Outgoing character; the result register is shifted so the current nibble is always on top.
    always_comb begin
        case (send_idx_q)
            IDX_W'(0): send_char = 8'h52;
            IDX_W'(1): send_char = 8'h45;
            IDX_W'(2): send_char = 8'h53;
            IDX_W'(3): send_char = 8'h50;
            IDX_W'(4): send_char = 8'h3A;
            LAST_BYTE: send_char = CH_LF;
            default:   send_char = hex_ascii(res_q[NONCE_W-1 -: 4]);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        nib_cnt_d    = nib_cnt_q;
        cr_seen_d    = cr_seen_q;
        byte_tmr_d   = '0;
        core_tmr_d   = '0;
        nonce_d      = core_nonce;
        res_d        = res_q;
        send_idx_d   = send_idx_q;
        outst_d      = outst_q;
        seen_busy_d  = seen_busy_q;
        acc_cnt_d    = acc_cnt_q;
        tx_data_d    = tx_data;
        tx_valid_d   = 1'b0;
        core_start_d = 1'b0;
        parse_err_d  = 1'b0;
        resp_done_d  = 1'b0;
        advance      = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (rx_valid && rx_data == CH_C) begin
                    state_d   = S_HDR;
                    hdr_idx_d = 3'd1;
                end
            end
            S_HDR, S_HEX, S_EOL: begin
                if (byte_expired) begin
                    parse_err_d = 1'b1;
                    state_d     = S_HUNT;
                end else if (rx_valid) begin
                    case (state_q)
                        S_HDR: begin
                            if (rx_data == hdr_exp) begin
                                if (hdr_idx_q == 3'd4) begin
                                    state_d   = S_HEX;
                                    nib_cnt_d = '0;
                                end else begin
                                    hdr_idx_d = hdr_idx_q + 3'd1;
                                end
                            end else if (rx_data == CH_C) begin
                                hdr_idx_d = 3'd1;
                            end else begin
                                state_d = S_HUNT;
                            end
                        end
                        S_HEX: begin
                            if (rx_hex[4]) begin
                                nonce_d   = {core_nonce[NONCE_W-5:0], rx_hex[3:0]};
                                nib_cnt_d = nib_cnt_q + IDX_W'(1);
                                if (nib_cnt_q == LAST_NIB) begin
                                    state_d   = S_EOL;
                                    cr_seen_d = 1'b0;
                                end
                            end else begin
                                parse_err_d = 1'b1;
                                state_d     = S_HUNT;
                            end
                        end
                        default: begin
                            if (rx_data == CH_LF) begin
                                state_d = S_START;
                            end else if (rx_data == CH_CR && !cr_seen_q) begin
                                cr_seen_d = 1'b1;
                            end else begin
                                parse_err_d = 1'b1;
                                state_d     = S_HUNT;
                            end
                        end
                    endcase
                end else begin
                    byte_tmr_d = byte_tmr_q + BTMR_W'(1);
                end
            end
            S_START: begin
                if (core_ready) begin
                    core_start_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_valid) begin
                    res_d       = core_result;
                    send_idx_d  = '0;
                    outst_d     = 1'b0;
                    state_d     = S_SEND;
                end else if (core_tmr_q == CORE_TIMEOUT) begin
                    parse_err_d = 1'b1;
                    state_d     = S_HUNT;
                end else begin
                    core_tmr_d = core_tmr_q + CTMR_W'(1);
                end
            end
            S_SEND: begin
                // A byte is done once busy has pulsed, or if busy never rose within 2 cycles.
                if (!outst_q) begin
                    if (!tx_busy) begin
                        tx_data_d   = send_char;
                        tx_valid_d  = 1'b1;
                        outst_d     = 1'b1;
                        seen_busy_d = 1'b0;
                        acc_cnt_d   = 2'd0;
                    end
                end else if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q || acc_cnt_q == 2'd2) begin
                    advance = 1'b1;
                end else begin
                    acc_cnt_d = acc_cnt_q + 2'd1;
                end

                if (advance) begin
                    outst_d = 1'b0;
                    if (send_idx_q == LAST_BYTE) begin
                        resp_done_d = 1'b1;
                        state_d     = S_HUNT;
                    end else begin
                        send_idx_d = send_idx_q + IDX_W'(1);
                        if (send_idx_q >= FIRST_HEX) begin
                            res_d = res_q << 4;
                        end
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        busy_d = (state_d != S_HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            hdr_idx_q   <= '0;
            nib_cnt_q   <= '0;
            cr_seen_q   <= 1'b0;
            byte_tmr_q  <= '0;
            core_tmr_q  <= '0;
            core_nonce  <= '0;
            res_q       <= '0;
            send_idx_q  <= '0;
            outst_q     <= 1'b0;
            seen_busy_q <= 1'b0;
            acc_cnt_q   <= '0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            parse_err   <= 1'b0;
            resp_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            nib_cnt_q   <= nib_cnt_d;
            cr_seen_q   <= cr_seen_d;
            byte_tmr_q  <= byte_tmr_d;
            core_tmr_q  <= core_tmr_d;
            core_nonce  <= nonce_d;
            res_q       <= res_d;
            send_idx_q  <= send_idx_d;
            outst_q     <= outst_d;
            seen_busy_q <= seen_busy_d;
            acc_cnt_q   <= acc_cnt_d;
            tx_data     <= tx_data_d;
            tx_valid    <= tx_valid_d;
            core_start  <= core_start_d;
            busy        <= busy_d;
            parse_err   <= parse_err_d;
            resp_done   <= resp_done_d;
        end
    end

endmodule

// File: tb/tb_chal_responder.sv
// Scoreboard bench for chal_responder with behavioural uart_tx and ChaCha20 core models.
module tb_chal_responder;
    localparam logic [23:0] BTO = 24'd500;
    localparam logic [15:0] CTO = 16'd1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_busy;
    logic         core_start;
    logic         core_ready;
    logic [127:0] core_nonce;
    logic [127:0] core_result;
    logic         core_valid;
    logic         busy;
    logic         parse_err;
    logic         resp_done;

    chal_responder #(.BYTE_TIMEOUT(BTO), .CORE_TIMEOUT(CTO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .core_start(core_start), .core_ready(core_ready), .core_nonce(core_nonce),
        .core_result(core_result), .core_valid(core_valid), .busy(busy),
        .parse_err(parse_err), .resp_done(resp_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_err = 0, n_done = 0, tx_seen = 0;
    logic [7:0]   tx_q[$];
    logic [127:0] nonce_q[$];
    logic [127:0] core_val = '0;
    int           core_lat = 300;
    bit           core_respond = 1'b1;
    int           busy_len = 10;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_resp(input string s);
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
        tx_q.push_back(8'h0A);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("resp_done_count", 128'(n_done), 128'(target));
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("tx_byte_count", 128'(tx_seen), 128'(target));
    endtask

    // uart_tx model: busy rises the cycle after tx_valid and stays up busy_len cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_valid) begin
                @(posedge clk); #1;
                tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // ChaCha20 core model: returns core_val core_lat cycles after core_start
    initial begin
        core_ready  = 1'b1;
        core_valid  = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk); #1;
            if (core_start && core_respond) begin
                core_ready = 1'b0;
                repeat (core_lat) @(posedge clk);
                #1;
                core_result = core_val;
                core_valid  = 1'b1;
                @(posedge clk); #1;
                core_valid  = 1'b0;
                core_ready  = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_valid) begin
                    tx_seen++;
                    chk("no_tx_valid_while_busy", 128'(tx_busy), 128'd0);
                    if (tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                    end else begin
                        chk("tx_byte", 128'(tx_data), 128'(tx_q.pop_front()));
                    end
                end
                if (core_start) begin
                    n_start++;
                    if (nonce_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL core_start_unexpected: got %0h expected none", core_nonce);
                    end else begin
                        chk("core_nonce", core_nonce, nonce_q.pop_front());
                    end
                end
                if (parse_err) n_err++;
                if (resp_done) n_done++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_err, t_start, t_tx;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        wait_cycles(3);
        #1;
        chk("rst_tx_data", 128'(tx_data), 128'd0);
        chk("rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_core_start", 128'(core_start), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_parse_err", 128'(parse_err), 128'd0);
        chk("rst_resp_done", 128'(resp_done), 128'd0);
        chk("rst_core_nonce", core_nonce, 128'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // basic challenge
        core_val = 128'hDEADBEEF00000000CAFEBABE12345678;
        nonce_q.push_back(128'h0123456789ABCDEF0011223344556677);
        push_resp("RESP:DEADBEEF00000000CAFEBABE12345678");
        send_str("CHAL:0123456789ABCDEF0011223344556677");
        send_byte(8'h0A);
        wait_done(1, 3000);
        wait_cycles(2);
        chk("t1_starts", 128'(n_start), 128'd1);
        chk("t1_errs", 128'(n_err), 128'd0);
        chk("t1_txq_left", 128'(tx_q.size()), 128'd0);
        chk("t1_idle", 128'(busy), 128'd0);
        chk("t1_nonce_held", core_nonce, 128'h0123456789ABCDEF0011223344556677);

        // lowercase header ignored, lowercase hex with CR LF accepted
        core_val = 128'h00112233445566778899AABBCCDDEEFF;
        send_str("chal:1234");
        send_byte(8'h0A);
        chk("t2_lower_ignored", 128'(busy), 128'd0);
        nonce_q.push_back({128{1'b1}});
        push_resp("RESP:00112233445566778899AABBCCDDEEFF");
        send_str("CHAL:ffffffffffffffffffffffffffffffff");
        send_byte(8'h0D);
        send_byte(8'h0A);
        wait_done(2, 3000);
        chk("t2_starts", 128'(n_start), 128'd2);
        chk("t2_errs", 128'(n_err), 128'd0);

        // resync on doubled C
        core_val = 128'hFEDCBA9876543210FEDCBA9876543210;
        nonce_q.push_back(128'd0);
        push_resp("RESP:FEDCBA9876543210FEDCBA9876543210");
        send_str("CCHAL:00000000000000000000000000000000");
        send_byte(8'h0A);
        wait_done(3, 3000);
        chk("t3_starts", 128'(n_start), 128'd3);
        chk("t3_errs", 128'(n_err), 128'd0);

        // bad hex char, then double CR, then a good line
        send_str("CHAL:0123456789G");
        wait_cycles(3);
        chk("t4_bad_hex_err", 128'(n_err), 128'd1);
        chk("t4_bad_hex_idle", 128'(busy), 128'd0);
        send_str("CHAL:22222222222222222222222222222222");
        send_byte(8'h0D);
        send_byte(8'h0D);
        wait_cycles(3);
        chk("t4_double_cr_err", 128'(n_err), 128'd2);
        chk("t4_no_start", 128'(n_start), 128'd3);
        core_val = 128'h1;
        nonce_q.push_back(128'h1);
        push_resp("RESP:00000000000000000000000000000001");
        send_str("CHAL:00000000000000000000000000000001");
        send_byte(8'h0A);
        wait_done(4, 3000);
        chk("t4_starts", 128'(n_start), 128'd4);
        chk("t4_errs", 128'(n_err), 128'd2);

        // byte timeout
        send_str("CHAL:12345");
        wait_cycles(400);
        chk("t5_before_timeout_busy", 128'(busy), 128'd1);
        chk("t5_before_timeout_err", 128'(n_err), 128'd2);
        wait_cycles(200);
        chk("t5_byte_timeout_err", 128'(n_err), 128'd3);
        chk("t5_byte_timeout_idle", 128'(busy), 128'd0);

        // core timeout
        core_respond = 1'b0;
        t_tx = tx_seen;
        nonce_q.push_back(128'h11111111111111111111111111111111);
        send_str("CHAL:11111111111111111111111111111111");
        send_byte(8'h0A);
        wait_cycles(900);
        chk("t5_core_wait_busy", 128'(busy), 128'd1);
        wait_cycles(200);
        chk("t5_core_timeout_err", 128'(n_err), 128'd4);
        chk("t5_core_timeout_idle", 128'(busy), 128'd0);
        chk("t5_core_timeout_starts", 128'(n_start), 128'd5);
        chk("t5_core_timeout_no_tx", 128'(tx_seen), 128'(t_tx));
        core_respond = 1'b1;

        // slow uart, bytes injected during SEND, reset mid-line
        busy_len = 1000;
        core_val = 128'hDEADBEEF00000000CAFEBABE12345678;
        t_err   = n_err;
        t_start = n_start;
        t_tx    = tx_seen;
        nonce_q.push_back(128'h0123456789ABCDEF0011223344556677);
        push_resp("RESP:DEADBEEF00000000CAFEBABE12345678");
        send_str("CHAL:0123456789ABCDEF0011223344556677");
        send_byte(8'h0A);
        wait_tx(t_tx + 5, 10000);
        send_str("CHAL:33333333333333333333333333333333");
        send_byte(8'h0A);
        wait_tx(t_tx + 20, 25000);
        chk("t6_injected_ignored", 128'(n_start), 128'(t_start + 1));
        chk("t6_no_err", 128'(n_err), 128'(t_err));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("t6_rst_tx_data", 128'(tx_data), 128'd0);
        chk("t6_rst_busy", 128'(busy), 128'd0);
        chk("t6_rst_core_start", 128'(core_start), 128'd0);
        chk("t6_rst_parse_err", 128'(parse_err), 128'd0);
        chk("t6_rst_resp_done", 128'(resp_done), 128'd0);
        chk("t6_rst_core_nonce", core_nonce, 128'd0);
        tx_q.delete();
        wait_cycles(5);
        #1;
        rst_n = 1'b1;
        wait_cycles(1100);
        chk("t6_abandoned_no_more_tx", 128'(tx_seen), 128'(t_tx + 20));
        chk("t6_abandoned_no_done", 128'(n_done), 128'd4);
        chk("t6_after_reset_idle", 128'(busy), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chal_responder.md
Name: chal_responder

Overview:
- Responder end of the UART challenge-response link.
- Parses an incoming "CHAL:" + 32 hex chars + LF line (38 bytes) from the uart_rx byte stream into a 128-bit nonce.
- Drives an external chacha20_compact instance, which holds the shared secret key, to compute the 128-bit result.
- Transmits "RESP:" + 32 uppercase hex chars + LF (38 bytes) through the uart_tx byte interface. Used on the probe/host-side FPGA paired with the authenticating board.

Parameters:
- BYTE_TIMEOUT, 24'd1_200_000: max cycles allowed between consecutive bytes inside one CHAL line (100 ms at 12 MHz); 0 disables.
- CORE_TIMEOUT, 16'd20_000: max cycles from core_start to core_valid before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to uart_tx, held stable until the next byte
- tx_valid  out  1  one-cycle strobe requesting transmission of tx_data
- tx_busy  in  1  uart_tx busy
- core_start  out  1  one-cycle start pulse to the ChaCha20 core
- core_ready  in  1  core idle and able to accept start
- core_nonce  out  128  latched challenge, stable from core_start until the next challenge
- core_result  in  128  core output block
- core_valid  in  1  core result valid (level or pulse accepted)
- busy  out  1  high in any state other than HUNT
- parse_err  out  1  one-cycle pulse on malformed line, byte timeout or core timeout
- resp_done  out  1  one-cycle pulse after the LF of RESP has completed transmission

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State HUNT; hdr_idx=0; nibble count=0; timers=0.
  - tx_data=8'h00; tx_valid, core_start, parse_err, resp_done, busy all 0; core_nonce=0.
- HUNT:
  - rx byte 'C' (8'h43) -> HDR, hdr_idx=1. Any other byte is ignored.
- HDR: expects "HAL:" at hdr_idx 1..4.
  - Match -> hdr_idx+1; after ':' -> HEX, nibble count=0.
  - Mismatch byte 'C' -> stay in HDR, hdr_idx=1 (resync).
  - Mismatch byte other than 'C' -> HUNT, no parse_err.
- HEX:
  - Accepts '0'-'9', 'A'-'F', 'a'-'f'. Each char shifts into core_nonce from the LSB end, so the first char lands in bits [127:124] after 32 chars.
  - Non-hex char -> parse_err pulse, HUNT; core_nonce keeps its partially shifted value, is not used, and is overwritten by the next challenge.
  - After the 32nd char -> EOL.
- EOL:
  - LF (8'h0A) -> START.
  - CR (8'h0D) is ignored once; a second CR, or any other byte, -> parse_err, HUNT.
- Byte timeout: in HDR/HEX/EOL, a counter cleared on every rx_valid. Reaching BYTE_TIMEOUT -> parse_err, HUNT.
- START: wait for core_ready=1, then assert core_start for exactly 1 cycle -> WAIT.
- WAIT:
  - core_valid=1 -> latch core_result into an internal result register -> SEND, send_idx=0.
  - CORE_TIMEOUT cycles without core_valid -> parse_err, HUNT.
- SEND: 38 bytes: 'R','E','S','P',':', result nibbles [127:124] down to [3:0] as uppercase ASCII ('0'-'9' = 8'h30+n, 'A'-'F' = 8'h37+n), then 8'h0A.
  - Byte issue: when tx_busy=0 and no byte is outstanding, drive tx_data and pulse tx_valid, then mark the byte outstanding.
  - Outstanding clears once tx_busy has been seen high and has then returned low. send_idx increments at that moment.
  - If tx_busy does not rise within 2 cycles of tx_valid, treat it as accepted: outstanding clears and send_idx increments.
  - After the LF clears: resp_done pulse -> HUNT.
- Bytes arriving in START/WAIT/SEND are discarded, with no error. A new CHAL is recognised only after returning to HUNT.
- rx_valid coincident with a timeout expiry: the timeout wins and the byte is dropped.
- Reset mid-SEND: the partial line is abandoned. Outputs return to reset values within the reset assertion, with no glitch pulse on tx_valid.
- busy = (state != HUNT).

Test Plan:
1. Send "CHAL:0123456789ABCDEF0011223344556677\n"; model core returns 128'hDEADBEEF00000000CAFEBABE12345678 after 300 cycles -> core_nonce=128'h0123456789ABCDEF0011223344556677, exactly 1 core_start, TX emits "RESP:DEADBEEF00000000CAFEBABE12345678\n", resp_done once.
2. Lowercase "chal" header, then "CHAL:" with lowercase hex "ffffffffffffffffffffffffffffffff\r\n" -> the first header is ignored; nonce is all ones; response is sent.
3. "CCHAL:" + 32 zeros + "\n" -> resync on the second 'C'; nonce 0; response sent; no parse_err.
4. "CHAL:" + 10 hex + 'G' -> parse_err 1 pulse, no core_start; a following valid line is processed normally.
5. "CHAL:" + 5 hex, then silence for BYTE_TIMEOUT cycles -> parse_err at timeout, busy=0. Core never asserts core_valid after start -> parse_err after CORE_TIMEOUT.
6. Hold tx_busy high 1000 cycles per byte and inject rx bytes during SEND -> 38 bytes in order, no tx_valid while busy, injected bytes ignored. Assert rst_n low at byte 20 -> all outputs return to 0 immediately.
